// File: rtl/RS5_pkg.sv
// rtl/RS5_pkg.sv - shared types and constants for the UART transmit arbiter
package RS5_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_LOCKED,
        ARB_ISSUE,
        ARB_HOLD,
        ARB_WAIT
    } uart_arb_state_t;

    localparam logic [7:0] UART_EOL = 8'h0A;

endpackage

// File: rtl/uart_rr_picker.sv
// rtl/uart_rr_picker.sv - combinational round-robin picker: first set request at or above ptr, with wrap
module uart_rr_picker #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int W = $clog2(N);

    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = W'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, line-locked sharing of one UART transmitter between N_REQ producers
// Optional owner-idle lock release: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import RS5_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int MAX_BURST = 64,
    parameter int TIMEOUT   = 256
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_REQ-1:0]      req_valid_i,
    input  logic [N_REQ-1:0][7:0] req_data_i,
    output logic [N_REQ-1:0]      req_ready_o,
    output logic [N_REQ-1:0]      grant_o,
    output logic                  uart_send_o,
    output logic [7:0]            uart_data_o,
    input  logic                  uart_ready_i,
    output logic                  busy_o
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int BC_W  = $clog2(MAX_BURST + 1);

    uart_arb_state_t  state, state_nxt;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] rr_next;
    logic [BC_W-1:0]  burst_cnt;
    logic             release_flag;

    logic [N_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    logic             owner_valid;
    logic [7:0]       owner_byte;
    logic             xfer;
    logic             timeout_hit;

    uart_rr_picker #(.N(N_REQ)) u_picker (
        .req (req_valid_i),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign owner_valid = req_valid_i[owner];
    assign owner_byte  = req_data_i[owner];
    assign xfer        = (state == ARB_LOCKED) && owner_valid && uart_ready_i;
    assign rr_next     = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
    assign busy_o      = (state != ARB_IDLE);

`ifdef UART_ARB_TIMEOUT_EN
    localparam int IC_W = $clog2(TIMEOUT + 1);
    logic [IC_W-1:0] idle_cnt;

    assign timeout_hit = (state == ARB_LOCKED) && !owner_valid && (idle_cnt == IC_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt <= '0;
        end else if (state != ARB_LOCKED || xfer) begin
            idle_cnt <= '0;
        end else if (!owner_valid) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    // Release only on EOL or burst limit; the comparison just keeps TIMEOUT referenced.
    assign timeout_hit = 1'b0 & (TIMEOUT == 0);
`endif

    always_comb begin
        req_ready_o = '0;
        if (state == ARB_LOCKED) begin
            req_ready_o[owner] = owner_valid && uart_ready_i;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:   if (pick_any) state_nxt = ARB_LOCKED;
            ARB_LOCKED: begin
                if (xfer)             state_nxt = ARB_ISSUE;
                else if (timeout_hit) state_nxt = ARB_IDLE;
            end
            ARB_ISSUE:  state_nxt = ARB_HOLD;
            // The transmitter needs a cycle after SEND before its READY is meaningful.
            ARB_HOLD:   state_nxt = ARB_WAIT;
            ARB_WAIT:   if (uart_ready_i) state_nxt = release_flag ? ARB_IDLE : ARB_LOCKED;
            default:    state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_o      <= '0;
            owner        <= '0;
            rr_ptr       <= '0;
            burst_cnt    <= '0;
            release_flag <= 1'b0;
            uart_send_o  <= 1'b0;
            uart_data_o  <= '0;
        end else begin
            uart_send_o <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        grant_o      <= pick_gnt;
                        owner        <= pick_idx;
                        burst_cnt    <= '0;
                        release_flag <= 1'b0;
                    end
                end
                ARB_LOCKED: begin
                    if (xfer) begin
                        uart_data_o  <= owner_byte;
                        uart_send_o  <= 1'b1;
                        burst_cnt    <= burst_cnt + 1'b1;
                        release_flag <= (owner_byte == UART_EOL) ||
                                        (burst_cnt == BC_W'(MAX_BURST - 1));
                    end else if (timeout_hit) begin
                        grant_o <= '0;
                        rr_ptr  <= rr_next;
                    end
                end
                ARB_WAIT: begin
                    if (uart_ready_i && release_flag) begin
                        grant_o <= '0;
                        rr_ptr  <= rr_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter with a READY-drops-10-cycles UART model
module tb_uart_tx_arbiter;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [1:0]      req_valid = '0;
    logic [1:0][7:0] req_data = '0;
    logic [1:0]      req_ready;
    logic [1:0]      grant;
    logic            uart_send;
    logic [7:0]      uart_data;
    logic            uart_ready = 1'b1;
    logic            busy;

    uart_tx_arbiter #(.N_REQ(2), .MAX_BURST(4), .TIMEOUT(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid_i  (req_valid),
        .req_data_i   (req_data),
        .req_ready_o  (req_ready),
        .grant_o      (grant),
        .uart_send_o  (uart_send),
        .uart_data_o  (uart_data),
        .uart_ready_i (uart_ready),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic       en0 = 1'b0;
    logic       en1 = 1'b0;
    logic [1:0] pend = '0;
    int         rdy_cnt = 0;
    logic       hold_low = 1'b0;
    int         send_cnt = 0;
    logic [7:0] log_data[$];
    logic [1:0] log_gnt[$];
    logic [7:0] exp_data[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: UART model and requester drive on the negedge, handshake sampled 1 time unit later.
    task automatic step();
        @(negedge clk);
        if (uart_send) begin
            send_cnt++;
            log_data.push_back(uart_data);
            log_gnt.push_back(grant);
            rdy_cnt = 10;
        end else if (rdy_cnt > 0) begin
            rdy_cnt--;
        end
        uart_ready = !hold_low && (rdy_cnt == 0);
        if (pend[0] && q0.size() > 0) void'(q0.pop_front());
        if (pend[1] && q1.size() > 0) void'(q1.pop_front());
        req_valid[0] = en0 && (q0.size() > 0);
        req_valid[1] = en1 && (q1.size() > 0);
        req_data[0]  = (q0.size() > 0) ? q0[0] : 8'h00;
        req_data[1]  = (q1.size() > 0) ? q1[0] : 8'h00;
        #1;
        pend = req_valid & req_ready;
    endtask

    task automatic wait_grant(input string tag);
        int n = 0;
        while (grant == 2'b00 && n < 100) begin
            step();
            n++;
        end
        check(tag, {31'd0, grant != 2'b00}, 32'd1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (!((en0 ? q0.size() : 0) == 0 && (en1 ? q1.size() : 0) == 0 &&
                 pend == 2'b00 && !busy) && n < 1000) begin
            step();
            n++;
        end
        check(tag, {31'd0, n < 1000}, 32'd1);
    endtask

    task automatic check_log(input string tag);
        check({tag, "_len"}, log_data.size(), exp_data.size());
        for (int i = 0; i < exp_data.size(); i++) begin
            check($sformatf("%s_b%0d", tag, i),
                  (i < log_data.size()) ? {24'd0, log_data[i]} : 32'hDEAD, {24'd0, exp_data[i]});
        end
    endtask

    task automatic clear_log();
        log_data.delete();
        log_gnt.delete();
        exp_data.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int base;
        logic any_rdy;

        // 1: reset values, reset mid-WAIT, first grant after reset goes to req0
        repeat (3) step();
        check("rst_grant", grant, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_send", uart_send, 1'b0);
        check("rst_data", uart_data, 8'h00);
        check("rst_ready", req_ready, 2'b00);
        reset_n = 1'b1;
        step();
        q0.push_back(8'h55);
        en0 = 1'b1;
        n = 0;
        while (send_cnt == 0 && n < 100) begin step(); n++; end
        check("t1_send_seen", send_cnt, 1);
        repeat (3) step();
        check("t1_busy_wait", busy, 1'b1);
        check("t1_data_wait", uart_data, 8'h55);
        #2 reset_n = 1'b0;
        #1;
        check("t1_async_grant", grant, 2'b00);
        check("t1_async_busy", busy, 1'b0);
        check("t1_async_send", uart_send, 1'b0);
        check("t1_async_data", uart_data, 8'h00);
        check("t1_async_ready", req_ready, 2'b00);
        pend = '0;
        q0.delete();
        q1.delete();
        en0 = 1'b0;
        en1 = 1'b0;
        req_valid = '0;
        step();
        step();
        reset_n = 1'b1;
        n = 0;
        while (!uart_ready && n < 50) begin step(); n++; end
        check("t1_uart_ready_back", uart_ready, 1'b1);
        q0.push_back(8'h31); q0.push_back(8'h0A);
        q1.push_back(8'h32); q1.push_back(8'h0A);
        en0 = 1'b1;
        en1 = 1'b1;
        wait_grant("t1_grant_seen");
        check("t1_first_grant", grant, 2'b01);
        drain("t1_drain");

        // 2: single line from req0, then round-robin hands the next grant to req1
        clear_log();
        en1 = 1'b0;
        q0.push_back(8'h41); q0.push_back(8'h42); q0.push_back(8'h0A);
        exp_data.push_back(8'h41); exp_data.push_back(8'h42); exp_data.push_back(8'h0A);
        en0 = 1'b1;
        drain("t2_drain");
        check_log("t2_log");
        for (int i = 0; i < log_gnt.size(); i++) check($sformatf("t2_gnt%0d", i), log_gnt[i], 2'b01);
        check("t2_grant_after", grant, 2'b00);
        q0.push_back(8'h11); q0.push_back(8'h0A);
        q1.push_back(8'h22); q1.push_back(8'h0A);
        en1 = 1'b1;
        wait_grant("t2_grant_seen");
        check("t2_rr_grant", grant, 2'b10);
        drain("t2_drain2");

        // 3: line lock while the owner pauses
        clear_log();
        en1 = 1'b0;
        q0.push_back(8'h61); q0.push_back(8'h62);
        en0 = 1'b1;
        wait_grant("t3_grant_seen");
        check("t3_owner", grant, 2'b01);
        q1.push_back(8'h77); q1.push_back(8'h0A);
        en1 = 1'b1;
        n = 0;
        while (q0.size() != 0 && n < 100) begin step(); n++; end
        repeat (50) step();
`ifndef UART_ARB_TIMEOUT_EN
        check("t3_lock_held", grant, 2'b01);
`endif
        q0.push_back(8'h0A);
        drain("t3_drain");
`ifdef UART_ARB_TIMEOUT_EN
        exp_data.push_back(8'h61); exp_data.push_back(8'h62);
        exp_data.push_back(8'h77); exp_data.push_back(8'h0A); exp_data.push_back(8'h0A);
`else
        exp_data.push_back(8'h61); exp_data.push_back(8'h62); exp_data.push_back(8'h0A);
        exp_data.push_back(8'h77); exp_data.push_back(8'h0A);
`endif
        check_log("t3_log");

        // 4: MAX_BURST=4 forces rotation after four bytes
        clear_log();
        en1 = 1'b0;
        for (int i = 1; i <= 6; i++) q0.push_back(8'(i));
        q0.push_back(8'h0A);
        en0 = 1'b1;
        wait_grant("t4_grant_seen");
        q1.push_back(8'hA1); q1.push_back(8'h0A);
        en1 = 1'b1;
        drain("t4_drain");
        exp_data.push_back(8'h01); exp_data.push_back(8'h02); exp_data.push_back(8'h03);
        exp_data.push_back(8'h04); exp_data.push_back(8'hA1); exp_data.push_back(8'h0A);
        exp_data.push_back(8'h05); exp_data.push_back(8'h06); exp_data.push_back(8'h0A);
        check_log("t4_log");
        check("t4_gnt_b3", (log_gnt.size() > 3) ? log_gnt[3] : 2'b11, 2'b01);
        check("t4_gnt_b4", (log_gnt.size() > 4) ? log_gnt[4] : 2'b11, 2'b10);
        check("t4_gnt_b6", (log_gnt.size() > 6) ? log_gnt[6] : 2'b11, 2'b01);

        // 5: READY held low while LOCKED, then accept same cycle and SEND next cycle
        clear_log();
        en1 = 1'b0;
        hold_low = 1'b1;
        q0.push_back(8'h5A);
        en0 = 1'b1;
        wait_grant("t5_grant_seen");
        base = send_cnt;
        any_rdy = 1'b0;
        repeat (20) begin
            step();
            if (req_ready != 2'b00) any_rdy = 1'b1;
        end
        check("t5_no_ready", any_rdy, 1'b0);
        check("t5_no_send", send_cnt, base);
        check("t5_locked", grant, 2'b01);
        hold_low = 1'b0;
        step();
        check("t5_accept", req_ready, 2'b01);
        step();
        check("t5_send", send_cnt, base + 1);
        check("t5_data", uart_data, 8'h5A);
        q0.push_back(8'h0A);
        drain("t5_drain");

        // 6: idle owner keeps the lock unless the timeout is built in
        clear_log();
        en1 = 1'b0;
        q0.push_back(8'h78);
        en0 = 1'b1;
        wait_grant("t6_grant_seen");
        q1.push_back(8'h33); q1.push_back(8'h0A);
        en1 = 1'b1;
        n = 0;
        while (q0.size() != 0 && n < 100) begin step(); n++; end
        repeat (40) step();
`ifdef UART_ARB_TIMEOUT_EN
        check("t6_moved", grant, 2'b10);
`else
        check("t6_held", grant, 2'b01);
`endif
        q0.push_back(8'h0A);
        drain("t6_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
